// File: rtl/level_detector_pkg.sv
// Shared definitions for the level detector: default widths (common with the
// moving-average stage) and the classifier state encoding.
package level_detector_pkg;

    localparam int DW_DEF = 10;   // sample / threshold width
    localparam int HW_DEF = 4;    // debounce hold count width
    localparam int EW_DEF = 16;   // rise event counter width

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } ld_state_e;

endpackage

// File: rtl/level_detector_if.sv
// Sample/config/result bundle between the filter side (master) and the
// level detector (slave).
interface level_detector_if
    import level_detector_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int HW = HW_DEF,
    parameter int EW = EW_DEF
) ();

    logic [DW-1:0] data_in;
    logic          e_in;
    logic [DW-1:0] th_hi;
    logic [DW-1:0] th_lo;
    logic [HW-1:0] hold;
    logic          clr_cnt;
    logic          level;
    logic          rise;
    logic          fall;
    logic [DW-1:0] peak;
    logic          peak_valid;
    logic [EW-1:0] evt_cnt;

    modport master (
        output data_in, e_in, th_hi, th_lo, hold, clr_cnt,
        input  level, rise, fall, peak, peak_valid, evt_cnt
    );

    modport slave (
        input  data_in, e_in, th_hi, th_lo, hold, clr_cnt,
        output level, rise, fall, peak, peak_valid, evt_cnt
    );

endinterface

// File: rtl/level_detector_debounce_counter.sv
// Consecutive-sample debounce counter shared by the rise and fall pending
// phases. done_o is combinational so the owning FSM can switch state on the
// same edge that accepts the completing sample.
module level_detector_debounce_counter
    import level_detector_pkg::*;
#(
    parameter int HW = HW_DEF
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          en_i,       // a sample is accepted this cycle
    input  logic          qualify_i,  // accepted sample meets the active threshold
    input  logic          restart_i,  // first qualifying sample of a new run
    input  logic [HW-1:0] hold_i,
    output logic          done_o
);

    logic [HW-1:0] count_q;
    logic [HW-1:0] count_d;
    logic [HW:0]   count_inc_s;
    logic [HW-1:0] hold_eff_s;
    logic          done_s;

    // Next count and completion flag; a hold of 0 behaves like a hold of 1.
    always_comb begin
        hold_eff_s  = (hold_i == {HW{1'b0}}) ? {{(HW-1){1'b0}}, 1'b1} : hold_i;
        count_inc_s = restart_i ? {{HW{1'b0}}, 1'b1}
                                : ({1'b0, count_q} + {{HW{1'b0}}, 1'b1});
        done_s      = 1'b0;
        count_d     = count_q;
        if (en_i) begin
            if (qualify_i) begin
                if (count_inc_s >= {1'b0, hold_eff_s}) begin
                    done_s  = 1'b1;
                    count_d = {HW{1'b0}};
                end else begin
                    count_d = count_inc_s[HW-1:0];
                end
            end else begin
                count_d = {HW{1'b0}};
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register; progress is kept across idle cycles.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_q <= {HW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = done_s;

endmodule

// File: rtl/level_detector.sv
// Hysteresis level classifier with debounced transitions, rise/fall pulses,
// per-episode peak capture and a saturating rise counter.
module level_detector
    import level_detector_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int HW = HW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic            clk,
    input  logic            nRST,
    level_detector_if.slave bus
);

    ld_state_e     state_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic [DW-1:0] peak_q;
    logic          peak_valid_q;
    logic [EW-1:0] evt_cnt_q;
    logic [DW-1:0] tracker_q;

    logic          hi_ok_s;
    logic          lo_ok_s;
    logic          qualify_s;
    logic          restart_s;
    logic          done_s;
    logic          rising_s;
    logic [DW-1:0] peak_max_s;

    // Threshold tests for the current state and running-max candidate.
    always_comb begin
        hi_ok_s    = (bus.data_in >= bus.th_hi);
        lo_ok_s    = (bus.data_in <= bus.th_lo);
        peak_max_s = (bus.data_in > tracker_q) ? bus.data_in : tracker_q;
        restart_s  = (state_q == ST_LOW) || (state_q == ST_HIGH);
        case (state_q)
            ST_LOW, ST_RISE_PEND:  qualify_s = hi_ok_s;
            ST_HIGH, ST_FALL_PEND: qualify_s = lo_ok_s;
            default:               qualify_s = hi_ok_s;
        endcase
        rising_s = bus.e_in && done_s &&
                   ((state_q == ST_LOW) || (state_q == ST_RISE_PEND));
    end

    level_detector_debounce_counter #(.HW(HW)) u_debounce (
        .clk       (clk),
        .nRST      (nRST),
        .en_i      (bus.e_in),
        .qualify_i (qualify_s),
        .restart_i (restart_s),
        .hold_i    (bus.hold),
        .done_o    (done_s)
    );

    // Classifier FSM with registered level, pulses, peak and tracker.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_LOW;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            peak_q       <= {DW{1'b0}};
            peak_valid_q <= 1'b0;
            tracker_q    <= {DW{1'b0}};
        end else begin
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            if (bus.e_in) begin
                case (state_q)
                    ST_LOW, ST_RISE_PEND: begin
                        if (done_s) begin
                            state_q   <= ST_HIGH;
                            level_q   <= 1'b1;
                            rise_q    <= 1'b1;
                            tracker_q <= bus.data_in;
                        end else if (hi_ok_s) begin
                            state_q <= ST_RISE_PEND;
                        end else begin
                            state_q <= ST_LOW;
                        end
                    end
                    ST_HIGH, ST_FALL_PEND: begin
                        tracker_q <= peak_max_s;
                        if (done_s) begin
                            state_q      <= ST_LOW;
                            level_q      <= 1'b0;
                            fall_q       <= 1'b1;
                            peak_q       <= peak_max_s;
                            peak_valid_q <= 1'b1;
                        end else if (lo_ok_s) begin
                            state_q <= ST_FALL_PEND;
                        end else begin
                            state_q <= ST_HIGH;
                        end
                    end
                    default: begin
                        state_q <= ST_LOW;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating rise counter; a clear wins over a simultaneous rise.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            evt_cnt_q <= {EW{1'b0}};
        end else if (bus.clr_cnt) begin
            evt_cnt_q <= {EW{1'b0}};
        end else if (rising_s && (evt_cnt_q != {EW{1'b1}})) begin
            evt_cnt_q <= evt_cnt_q + {{(EW-1){1'b0}}, 1'b1};
        end
    end

    assign bus.level      = level_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.peak       = peak_q;
    assign bus.peak_valid = peak_valid_q;
    assign bus.evt_cnt    = evt_cnt_q;

endmodule

// File: tb/tb_level_detector.sv
// Scoreboard bench for level_detector: the driver pushes the expected
// post-edge outputs of a run-length reference model, a monitor pops and
// compares one entry per clock. The event counter is narrowed to 8 bits so
// saturation is reached in a few hundred cycles.
module tb_level_detector;
    import level_detector_pkg::*;

    localparam int DW = 10;
    localparam int HW = 4;
    localparam int EW = 8;

    logic clk  = 1'b0;
    logic nRST = 1'b1;
    always #5 clk = ~clk;

    level_detector_if #(.DW(DW), .HW(HW), .EW(EW)) bus ();

    level_detector #(.DW(DW), .HW(HW), .EW(EW)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct packed {
        logic          level;
        logic          rise;
        logic          fall;
        logic [DW-1:0] peak;
        logic          pv;
        logic [EW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model: level plus length of the current qualifying run
    bit m_lvl, m_rise, m_fall, m_pv;
    int m_run, m_track, m_peak, m_cnt;
    int cfg_hi, cfg_lo, cfg_hold;

    task automatic model_reset();
        m_lvl = 0; m_rise = 0; m_fall = 0; m_pv = 0;
        m_run = 0; m_track = 0; m_peak = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit e, input int d, input bit clr);
        int need;
        bit rose;
        need   = (cfg_hold == 0) ? 1 : cfg_hold;
        rose   = 0;
        m_rise = 0; m_fall = 0; m_pv = 0;
        if (e) begin
            if (!m_lvl) begin
                if (d >= cfg_hi) m_run++; else m_run = 0;
                if (m_run >= need) begin
                    m_lvl = 1; m_run = 0; m_rise = 1; rose = 1; m_track = d;
                end
            end else begin
                if (d > m_track) m_track = d;
                if (d <= cfg_lo) m_run++; else m_run = 0;
                if (m_run >= need) begin
                    m_lvl = 0; m_run = 0; m_fall = 1; m_pv = 1; m_peak = m_track;
                end
            end
        end
        if (clr) m_cnt = 0;
        else if (rose && m_cnt < (1 << EW) - 1) m_cnt++;
    endtask

    task automatic drive(input bit e, input int d, input bit clr);
        exp_t x;
        @(negedge clk);
        bus.e_in    = e;
        bus.data_in = d[DW-1:0];
        bus.th_hi   = cfg_hi[DW-1:0];
        bus.th_lo   = cfg_lo[DW-1:0];
        bus.hold    = cfg_hold[HW-1:0];
        bus.clr_cnt = clr;
        model_step(e, d, clr);
        x.level = m_lvl; x.rise = m_rise; x.fall = m_fall;
        x.peak  = m_peak[DW-1:0]; x.pv = m_pv; x.cnt = m_cnt[EW-1:0];
        q.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // wait for the edge that applies the last driven sample
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // monitor: one expected entry per clock edge after it was driven
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a.level = bus.level; a.rise = bus.rise; a.fall = bus.fall;
                a.peak  = bus.peak;  a.pv   = bus.peak_valid; a.cnt = bus.evt_cnt;
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL scoreboard @%0t: got lvl=%0b rise=%0b fall=%0b peak=%0d pv=%0b cnt=%0d expected lvl=%0b rise=%0b fall=%0b peak=%0d pv=%0b cnt=%0d",
                             $time, a.level, a.rise, a.fall, a.peak, a.pv, a.cnt,
                             e.level, e.rise, e.fall, e.peak, e.pv, e.cnt);
                end
            end
        end
    end

    initial begin
        int mode;
        int d;
        bus.e_in = 1'b0; bus.data_in = '0; bus.th_hi = '0; bus.th_lo = '0;
        bus.hold = '0;   bus.clr_cnt = 1'b0;
        model_reset();
        cfg_hi = 600; cfg_lo = 400; cfg_hold = 3;

        #2 nRST = 1'b0;
        #1;
        chk("rst_level", bus.level, 0);
        chk("rst_rise", bus.rise, 0);
        chk("rst_fall", bus.fall, 0);
        chk("rst_peak", bus.peak, 0);
        chk("rst_pv", bus.peak_valid, 0);
        chk("rst_cnt", bus.evt_cnt, 0);
        @(negedge clk);
        nRST = 1'b1;

        // basic rise
        drive(1, 650, 0); drive(1, 700, 0); drive(1, 620, 0);
        settle();
        chk("basic_rise_level", bus.level, 1);
        chk("basic_rise_pulse", bus.rise, 1);
        chk("basic_rise_cnt", bus.evt_cnt, 1);

        // fall with peak
        drive(1, 800, 0); drive(1, 300, 0); drive(1, 350, 0); drive(1, 380, 0);
        settle();
        chk("fall_level", bus.level, 0);
        chk("fall_pulse", bus.fall, 1);
        chk("fall_pv", bus.peak_valid, 1);
        chk("fall_peak", bus.peak, 800);

        // debounce abort
        drive(1, 650, 0); drive(1, 590, 0);
        drive(1, 650, 0); drive(1, 650, 0); drive(1, 650, 0);
        settle();
        chk("abort_rise", bus.rise, 1);
        chk("abort_cnt", bus.evt_cnt, 2);

        // hysteresis band, HIGH then LOW
        for (int i = 0; i < 20; i++) drive(1, 500, 0);
        settle();
        chk("band_high", bus.level, 1);
        drive(1, 300, 0); drive(1, 300, 0); drive(1, 300, 0);
        for (int i = 0; i < 20; i++) drive(1, 500, 0);
        settle();
        chk("band_low", bus.level, 0);

        // hold=0 acts as 1
        cfg_hold = 0;
        drive(1, 600, 0);
        settle();
        chk("hold0_rise", bus.rise, 1);
        drive(1, 100, 0);

        // hold=2 with an idle gap in the middle
        cfg_hold = 2;
        drive(1, 610, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0);
        drive(1, 610, 0);
        settle();
        chk("gap_rise", bus.rise, 1);

        // asynchronous reset while in FALL_PEND
        cfg_hold = 3;
        drive(1, 300, 0); drive(1, 300, 0);
        @(posedge clk);
        #3 nRST = 1'b0;
        #1;
        chk("arst_level", bus.level, 0);
        chk("arst_peak", bus.peak, 0);
        chk("arst_cnt", bus.evt_cnt, 0);
        chk("arst_pulses", {bus.rise, bus.fall, bus.peak_valid}, 0);
        bus.e_in = 1'b0;
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        drive(1, 650, 0); drive(1, 650, 0); drive(1, 650, 0);

        // randomized phase
        mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) begin
                cfg_hi   = $urandom_range(300, 800);
                cfg_lo   = ($urandom_range(0, 7) == 0) ? cfg_hi + $urandom_range(1, 100)
                                                       : cfg_hi - $urandom_range(50, 250);
                cfg_hold = $urandom_range(0, 5);
            end
            if ($urandom_range(0, 5) == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       d = $urandom_range(cfg_hi, 1023);
                1:       d = $urandom_range(0, cfg_lo);
                default: d = $urandom_range(0, 1023);
            endcase
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 40) == 0);
        end

        // saturation of the rise counter
        cfg_hi = 600; cfg_lo = 400; cfg_hold = 1;
        for (int i = 0; i < 270; i++) begin
            drive(1, 1023, 0);
            drive(1, 0, 0);
        end
        settle();
        chk("evt_saturate", bus.evt_cnt, 255);

        // clear together with a rise: rise not counted
        drive(1, 1023, 1);
        settle();
        chk("clr_rise_pulse", bus.rise, 1);
        chk("clr_rise_cnt", bus.evt_cnt, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/level_detector.md
Name: level_detector

Overview:
- Downstream consumer of the moving-average filter output: takes filtered 10-bit samples with their valid strobe.
- Classifies the signal as HIGH or LOW using two thresholds with hysteresis.
- Debounces each transition over a programmable number of consecutive samples.
- Reports rise/fall event pulses, the peak value of each HIGH episode, and a saturating rise-event count for the control/readout logic.

Parameters:
- DW, 10, sample and threshold width
- HW, 4, width of debounce hold count
- EW, 16, width of event counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- nRST  input  1  asynchronous active-low reset
- data_in  input  DW  filtered sample (unsigned)
- e_in  input  1  sample valid strobe; one sample accepted per cycle when high
- th_hi  input  DW  rise threshold (sample >= th_hi qualifies)
- th_lo  input  DW  fall threshold (sample <= th_lo qualifies)
- hold  input  HW  consecutive qualifying samples required; 0 treated as 1
- clr_cnt  input  1  synchronous clear of evt_cnt
- level  output  1  debounced level, 1 = HIGH
- rise  output  1  one-cycle pulse on LOW->HIGH
- fall  output  1  one-cycle pulse on HIGH->LOW
- peak  output  DW  max sample of last completed HIGH episode
- peak_valid  output  1  one-cycle pulse, coincident with fall
- evt_cnt  output  EW  number of rises, saturating

Behaviour:
- Reset values: state LOW, level=0, rise=0, fall=0, peak=0, peak_valid=0, evt_cnt=0, debounce count=0, peak tracker=0. Reset takes effect asynchronously in any state, including mid-debounce.
- Idle cycles: cycles with e_in=0 change nothing except forcing rise/fall/peak_valid to 0; debounce progress is kept across gaps.
- Threshold configuration: th_hi, th_lo and hold are sampled per accepted sample and are not latched. th_lo > th_hi is legal; only the comparison relevant to the current state is evaluated.
- FSM states: LOW, RISE_PEND, HIGH, FALL_PEND.
- LOW: an accepted sample >= th_hi sets count=1. If the effective hold is 1, go to HIGH immediately; otherwise go to RISE_PEND.
- RISE_PEND, sample >= th_hi: count+1. When count+1 reaches the effective hold, go to HIGH; else stay.
- RISE_PEND, sample < th_hi: count=0, return to LOW.
- HIGH: an accepted sample <= th_lo sets count=1 and goes to FALL_PEND, or directly back to LOW when the effective hold is 1.
- FALL_PEND, sample <= th_lo: count+1. When count+1 reaches the effective hold, go to LOW; else stay.
- FALL_PEND, sample > th_lo: count=0, return to HIGH.
- Entering HIGH (registered, same edge as the accepting sample): level=1, rise=1, evt_cnt increments.
- Entering LOW from HIGH/FALL_PEND (registered, same edge): level=0, fall=1, peak=tracker value including the current sample, peak_valid=1.
- Latency: one clock from the accepting e_in edge to the output change.
- Peak tracker: loaded with the sample that completes the rise. Max-updated with every accepted sample while in HIGH or FALL_PEND, including the sample that completes the fall. peak holds its value until the next fall.
- evt_cnt: saturates at all ones and does not wrap.
- clr_cnt: sets evt_cnt to 0 on the next edge. It has priority over a simultaneous rise, and that rise is not counted. It does not affect the FSM.
- Internal counter width: the debounce count is HW bits. The comparison uses the effective hold: hold, or 1 when hold=0.

Decomposition:
- Shared package: state encoding (LOW/RISE_PEND/HIGH/FALL_PEND), DW/HW/EW defaults shared with the moving-average stage.
- One natural sub-module, debounce_counter: holds the count, with inputs qualify, restart and hold, and outputs done. The level_detector FSM instantiates it once and reuses it for both rise and fall pending.

Test Plan:
- Basic rise: th_hi=600, th_lo=400, hold=3, samples 650,700,620 -> rise and level=1 one clock after the third sample; evt_cnt=1.
- Debounce abort: samples 650,590,650,650,650 -> no rise after 590; rise after the fifth sample.
- Fall with peak: from HIGH, samples 800,300,350,380 (hold=3) -> fall, level=0 and peak_valid after 380; peak=800.
- Hysteresis band: level HIGH, samples 500 repeated 20 times -> level stays 1, no pulses. From LOW, 500 repeated -> stays 0.
- hold=0 and gaps: hold=0, sample 600 -> rise next clock. hold=2, samples 610, e_in low 5 cycles, then 610 -> rise after the second sample.
- Counter and reset: 65535 rises -> saturates at 65535; clr_cnt together with a rise -> evt_cnt=0. nRST asserted in FALL_PEND -> all outputs 0 immediately, state LOW.
